// File: rtl/uart_rx_controller.sv
// UART receive sequencer: buffers bytes flagged by the receiver in a FIFO, presents them
// on a valid/ready stream, tracks lost bytes and signals the end of a burst on line idle.
module uart_rx_controller #(
    parameter int WORD_SIZE  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int IDLE_CHARS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_enable,
    input  logic [WORD_SIZE-1:0]         rx_data,
    input  logic                         rx_avbl,
    output logic [WORD_SIZE-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overrun,
    output logic [7:0]                   overrun_cnt,
    input  logic                         clr_overrun,
    output logic                         idle_tick
);

    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int IDLE_CYCLES = (CLOCK_FREQ / BAUD_RATE) * 10 * IDLE_CHARS;
    localparam int IDLE_W      = $clog2(IDLE_CYCLES) + 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    typedef enum logic {
        QUIET  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_overrun;
    logic [7:0]           r_overrun_cnt;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDLE_W-1:0]    r_idle_cnt;
    logic [IDLE_W-1:0]    w_idle_cnt_nxt;
    logic                 r_idle_tick;
    logic                 w_idle_tick_nxt;

    logic                 w_push_req;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_push_req = rx_avbl && rx_enable;
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = out_valid && out_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign out_valid   = (r_count != '0);
    assign out_data    = r_mem[r_rd_ptr];
    assign fifo_count  = r_count;
    assign overrun     = r_overrun;
    assign overrun_cnt = r_overrun_cnt;
    assign idle_tick   = r_idle_tick;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A new loss outranks a simultaneous clear so the event is never hidden.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun     <= 1'b0;
            r_overrun_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overrun     <= 1'b1;
            r_overrun_cnt <= clr_overrun ? 8'd1 : sat_inc8(r_overrun_cnt);
        end else if (clr_overrun) begin
            r_overrun     <= 1'b0;
            r_overrun_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= QUIET;
            r_idle_cnt  <= '0;
            r_idle_tick <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idle_cnt  <= w_idle_cnt_nxt;
            r_idle_tick <= w_idle_tick_nxt;
        end
    end

    // Any byte offered while enabled is line activity, even one lost to overrun.
    always_comb begin
        w_state_nxt     = r_state;
        w_idle_cnt_nxt  = r_idle_cnt;
        w_idle_tick_nxt = 1'b0;
        case (r_state)
            QUIET: begin
                w_idle_cnt_nxt = '0;
                if (w_push_req) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_push_req) begin
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt == IDLE_LAST) begin
                    w_idle_tick_nxt = 1'b1;
                    w_idle_cnt_nxt  = '0;
                    w_state_nxt     = QUIET;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
                end
            end
            default: begin
                w_state_nxt    = QUIET;
                w_idle_cnt_nxt = '0;
            end
        endcase
    end

endmodule
